// File: rtl/pdp8_instr_decode.sv
// PDP-8 fetch/decode stage: fetches the word at PC, decodes it and holds it for instr_exec.
// Optional DEC_PERF_CNT_EN adds a saturating instr_count output.
package pdp8_pkg;

    typedef struct packed {
        logic        NOP;
        logic        AND;
        logic        TAD;
        logic        ISZ;
        logic        DCA;
        logic        JMS;
        logic        JMP;
        logic [11:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic CLA1, CLL, CMA, CML, RAR, RAL, RTR, RTL, IAC;
        logic CLA2, SMA, SZA, SNL, SPA, SNA, SZL, OSR, HLT;
    } pdp_op7_opcode_s;

    localparam pdp_mem_opcode_s MEM_NOP = '{NOP: 1'b1, default: '0};
    localparam pdp_op7_opcode_s OP7_NOP = '{NOP: 1'b1, default: '0};

endpackage

module pdp8_instr_decode
    import pdp8_pkg::*;
#(
    parameter logic [11:0] START_ADDR  = 12'o0200,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ifu_rd_req,
    output logic [11:0]     ifu_rd_addr,
    input  logic [11:0]     ifu_rd_data,
    input  logic            stall,
    input  logic [11:0]     PC_value,
    output logic [11:0]     base_addr,
    output pdp_mem_opcode_s pdp_mem_opcode,
    output pdp_op7_opcode_s pdp_op7_opcode,
    output logic            halted,
    output logic            dec_err
`ifdef DEC_PERF_CNT_EN
    ,
    output logic [31:0]     instr_count
`endif
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_DATA,
        S_DECODE,
        S_ISSUE,
        S_WAIT_EXEC,
        S_HALTED
    } state_e;

    state_e          state_q;
    logic [11:0]     pc_q;
    logic [11:0]     ir_q;
    logic            data_phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic            req_q;
    logic [11:0]     addr_q;
    logic [11:0]     base_q;
    pdp_mem_opcode_s mem_q;
    pdp_op7_opcode_s op7_q;
    logic            halted_q;
    logic            dec_err_q;

    pdp_mem_opcode_s mem_d;
    pdp_op7_opcode_s op7_d;
    logic [11:0]     base_d;
    logic            all_nop_d;
    logic [2:0]      op;

    assign op = ir_q[11:9];

    always_comb begin
        mem_d  = MEM_NOP;
        op7_d  = OP7_NOP;
        base_d = base_q;
        if (op <= 3'd5) begin
            mem_d = '0;
            case (op)
                3'd0:    mem_d.AND = 1'b1;
                3'd1:    mem_d.TAD = 1'b1;
                3'd2:    mem_d.ISZ = 1'b1;
                3'd3:    mem_d.DCA = 1'b1;
                3'd4:    mem_d.JMS = 1'b1;
                default: mem_d.JMP = 1'b1;
            endcase
            mem_d.mem_inst_addr = pc_q;
            base_d = ir_q[7] ? {pc_q[11:7], ir_q[6:0]} : {5'b0, ir_q[6:0]};
        end else if (op == 3'd7) begin
            op7_d = '0;
            if (!ir_q[8]) begin
                op7_d.CLA1 = ir_q[7];
                op7_d.CLL  = ir_q[6];
                op7_d.CMA  = ir_q[5];
                op7_d.CML  = ir_q[4];
                op7_d.RAR  = ir_q[3] & ~ir_q[1];
                op7_d.RAL  = ir_q[2] & ~ir_q[1];
                op7_d.RTR  = ir_q[3] & ir_q[1];
                op7_d.RTL  = ir_q[2] & ir_q[1];
                op7_d.IAC  = ir_q[0];
            end else if (!ir_q[0]) begin
                // IR[3] flips the sense of the three skip conditions
                op7_d.CLA2 = ir_q[7];
                op7_d.SMA  = ir_q[6] & ~ir_q[3];
                op7_d.SZA  = ir_q[5] & ~ir_q[3];
                op7_d.SNL  = ir_q[4] & ~ir_q[3];
                op7_d.SPA  = ir_q[6] & ir_q[3];
                op7_d.SNA  = ir_q[5] & ir_q[3];
                op7_d.SZL  = ir_q[4] & ir_q[3];
                op7_d.OSR  = ir_q[2];
                op7_d.HLT  = ir_q[1];
            end
            op7_d.NOP = ~|op7_d;
        end
    end

    assign all_nop_d = mem_d.NOP & op7_d.NOP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= START_ADDR;
            data_phase_q <= 1'b0;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            base_q       <= '0;
            mem_q        <= MEM_NOP;
            op7_q        <= OP7_NOP;
            halted_q     <= 1'b0;
            dec_err_q    <= 1'b0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    req_q        <= 1'b1;
                    addr_q       <= pc_q;
                    data_phase_q <= 1'b0;
                    state_q      <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    // first cycle carries the request, read data arrives on the second
                    data_phase_q <= 1'b1;
                    if (data_phase_q) begin
                        ir_q    <= ifu_rd_data;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    mem_q  <= mem_d;
                    op7_q  <= op7_d;
                    base_q <= base_d;
                    cnt_q  <= '0;
                    if (all_nop_d) begin
                        pc_q    <= pc_q + 12'd1;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (stall) begin
                        state_q <= S_WAIT_EXEC;
                    end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        dec_err_q <= 1'b1;
                        halted_q  <= 1'b1;
                        mem_q     <= MEM_NOP;
                        op7_q     <= OP7_NOP;
                        state_q   <= S_HALTED;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_EXEC: begin
                    if (!stall) begin
                        mem_q <= MEM_NOP;
                        op7_q <= OP7_NOP;
                        if (op7_q.HLT) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else begin
                            // launch the next read straight away to save a cycle
                            pc_q         <= PC_value;
                            req_q        <= 1'b1;
                            addr_q       <= PC_value;
                            data_phase_q <= 1'b0;
                            state_q      <= S_WAIT_DATA;
                        end
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef DEC_PERF_CNT_EN
    logic [31:0] instr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= '0;
        end else if (state_q == S_DECODE && instr_count_q != 32'hFFFF_FFFF) begin
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign instr_count = instr_count_q;
`endif

    assign ifu_rd_req     = req_q;
    assign ifu_rd_addr    = addr_q;
    assign base_addr      = base_q;
    assign pdp_mem_opcode = mem_q;
    assign pdp_op7_opcode = op7_q;
    assign halted         = halted_q;
    assign dec_err        = dec_err_q;

endmodule

// File: tb/tb_pdp8_instr_decode.sv
// Bench for pdp8_instr_decode: memory responder, word-level decode model, directed and random steps.
module tb_pdp8_instr_decode;
    import pdp8_pkg::*;

    logic            clk;
    logic            reset;
    logic            ifu_rd_req;
    logic [11:0]     ifu_rd_addr;
    logic [11:0]     ifu_rd_data;
    logic            stall;
    logic [11:0]     PC_value;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s pdp_mem_opcode;
    pdp_op7_opcode_s pdp_op7_opcode;
    logic            halted;
    logic            dec_err;

    int vec  = 0;
    int miss = 0;

    logic [11:0] mem [4096];
    logic [11:0] exp_base;
    logic [11:0] cur_pc;
    logic        prev_req;

    pdp8_instr_decode #(.START_ADDR(12'o0200), .ACK_TIMEOUT(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .stall          (stall),
        .PC_value       (PC_value),
        .base_addr      (base_addr),
        .pdp_mem_opcode (pdp_mem_opcode),
        .pdp_op7_opcode (pdp_op7_opcode),
        .halted         (halted),
        .dec_err        (dec_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level reference decode, written from the instruction-set bit meanings.
    function automatic void ref_decode(input logic [11:0] pc, input logic [11:0] w,
                                       output pdp_mem_opcode_s m, output pdp_op7_opcode_s o);
        int         opn;
        logic [5:0] oh;
        bit         rev;
        opn = int'(w) / 512;
        m = MEM_NOP;
        o = OP7_NOP;
        if (opn < 6) begin
            oh = 6'd1 << opn;
            m = '0;
            m.AND = oh[0]; m.TAD = oh[1]; m.ISZ = oh[2];
            m.DCA = oh[3]; m.JMS = oh[4]; m.JMP = oh[5];
            m.mem_inst_addr = pc;
        end else if (opn == 7) begin
            o = '0;
            if ((w & 12'o0400) == 0) begin
                o.CLA1 = (w & 12'o0200) != 0;
                o.CLL  = (w & 12'o0100) != 0;
                o.CMA  = (w & 12'o0040) != 0;
                o.CML  = (w & 12'o0020) != 0;
                o.RAR  = ((w & 12'o0010) != 0) && ((w & 12'o0002) == 0);
                o.RAL  = ((w & 12'o0004) != 0) && ((w & 12'o0002) == 0);
                o.RTR  = ((w & 12'o0010) != 0) && ((w & 12'o0002) != 0);
                o.RTL  = ((w & 12'o0004) != 0) && ((w & 12'o0002) != 0);
                o.IAC  = (w & 12'o0001) != 0;
            end else if ((w & 12'o0001) == 0) begin
                rev    = (w & 12'o0010) != 0;
                o.CLA2 = (w & 12'o0200) != 0;
                o.SMA  = ((w & 12'o0100) != 0) && !rev;
                o.SZA  = ((w & 12'o0040) != 0) && !rev;
                o.SNL  = ((w & 12'o0020) != 0) && !rev;
                o.SPA  = ((w & 12'o0100) != 0) && rev;
                o.SNA  = ((w & 12'o0040) != 0) && rev;
                o.SZL  = ((w & 12'o0020) != 0) && rev;
                o.OSR  = (w & 12'o0004) != 0;
                o.HLT  = (w & 12'o0002) != 0;
            end
            o.NOP = (o == '0);
        end
    endfunction

    function automatic logic [11:0] ref_base(input logic [11:0] pc, input logic [11:0] w,
                                             input logic [11:0] old);
        if (int'(w) / 512 >= 6) return old;
        if ((w & 12'o0200) != 0) return (pc & 12'o7600) | (w & 12'o0177);
        return w & 12'o0177;
    endfunction

    function automatic logic [11:0] rand_word();
        logic [11:0] w;
        w = 12'($urandom_range(0, 4095));
        if (w[11:9] == 3'd7 && w[8] && !w[0]) w[1] = 1'b0;
        return w;
    endfunction

    // Memory: address seen with a request, data presented for the following cycle only.
    initial begin
        logic [11:0] a;
        forever begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) begin
                a = ifu_rd_addr;
                @(posedge clk);
                #1 ifu_rd_data = mem[a];
                @(posedge clk);
                #1 ifu_rd_data = rand_word();
            end
        end
    end

    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (ifu_rd_req === 1'b1) check("req_single_pulse", {31'b0, prev_req}, 32'd0);
            prev_req = ifu_rd_req;
        end
    end

    task automatic check_reset_state();
        check("rst_req", ifu_rd_req, 0);
        check("rst_addr", ifu_rd_addr, 0);
        check("rst_base", base_addr, 0);
        check("rst_halted", halted, 0);
        check("rst_dec_err", dec_err, 0);
        check("rst_mem", pdp_mem_opcode, MEM_NOP);
        check("rst_op7", pdp_op7_opcode, OP7_NOP);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        exp_base = 12'o0000;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req", ifu_rd_req, 1);
        check("post_rst_addr", ifu_rd_addr, 12'o0200);
    endtask

    // Entered at the sample point where the fetch of pc is visible.
    task automatic run_one(input logic [11:0] pc, input logic [11:0] pcv, input int dly,
                           output logic [11:0] next_pc);
        logic [11:0]     w;
        pdp_mem_opcode_s em;
        pdp_op7_opcode_s eo;
        w = mem[pc];
        ref_decode(pc, w, em, eo);
        next_pc = pc;
        @(negedge clk);
        check("wd_req", ifu_rd_req, 0);
        check("wd_mem_nop", pdp_mem_opcode, MEM_NOP);
        @(negedge clk);
        check("dec_op7_nop", pdp_op7_opcode, OP7_NOP);
        @(negedge clk);
        exp_base = ref_base(pc, w, exp_base);
        check("out_mem", pdp_mem_opcode, em);
        check("out_op7", pdp_op7_opcode, eo);
        check("out_base", base_addr, exp_base);
        if (em.NOP && eo.NOP) begin
            check("nop_req_idle", ifu_rd_req, 0);
            @(negedge clk);
            next_pc = pc + 12'd1;
            check("nop_next_req", ifu_rd_req, 1);
            check("nop_next_addr", ifu_rd_addr, next_pc);
        end else begin
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                check("issue_hold_mem", pdp_mem_opcode, em);
                check("issue_hold_base", base_addr, exp_base);
                check("issue_no_err", dec_err, 0);
            end
            stall = 1'b1;
            @(negedge clk);
            check("exec_hold_op7", pdp_op7_opcode, eo);
            @(negedge clk);
            check("exec_hold_mem", pdp_mem_opcode, em);
            check("exec_req_idle", ifu_rd_req, 0);
            stall = 1'b0;
            PC_value = pcv;
            @(negedge clk);
            check("ret_mem_nop", pdp_mem_opcode, MEM_NOP);
            check("ret_op7_nop", pdp_op7_opcode, OP7_NOP);
            if (eo.HLT) begin
                check("hlt_halted", halted, 1);
                check("hlt_req", ifu_rd_req, 0);
            end else begin
                next_pc = pcv;
                check("ret_req", ifu_rd_req, 1);
                check("ret_addr", ifu_rd_addr, pcv);
                check("ret_halted", halted, 0);
            end
        end
    endtask

    initial begin
        pdp_mem_opcode_s em;
        pdp_op7_opcode_s eo;
        reset = 1'b1;
        stall = 1'b0;
        PC_value = 12'o0000;
        ifu_rd_data = 12'o0000;
        exp_base = 12'o0000;
        for (int i = 0; i < 4096; i++) mem[i] = rand_word();
        mem[12'o0200] = 12'o1250;
        mem[12'o0201] = 12'o5020;
        mem[12'o0300] = 12'o7300;
        mem[12'o0205] = 12'o6001;
        mem[12'o0206] = 12'o7402;

        do_reset();
        run_one(12'o0200, 12'o0201, 3, cur_pc);
        run_one(cur_pc, 12'o0300, 0, cur_pc);
        run_one(cur_pc, 12'o0205, 15, cur_pc);
        run_one(cur_pc, 12'o0000, 0, cur_pc);
        check("iot_skip_pc", cur_pc, 12'o0206);
        run_one(cur_pc, 12'o1234, 1, cur_pc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("halted_no_req", ifu_rd_req, 0);
        end
        check("halted_sticky", halted, 1);

        mem[12'o0200] = 12'o7001;
        mem[12'o0206] = rand_word();
        do_reset();
        ref_decode(12'o0200, 12'o7001, em, eo);
        repeat (3) @(negedge clk);
        check("to_iac", pdp_op7_opcode, eo);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("to_not_yet", dec_err, 0);
        end
        @(negedge clk);
        check("to_dec_err", dec_err, 1);
        check("to_halted", halted, 1);
        check("to_op7_nop", pdp_op7_opcode, OP7_NOP);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("to_no_req", ifu_rd_req, 0);
        end

        do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", ifu_rd_req, 0);
        check("mid_rst_op7", pdp_op7_opcode, OP7_NOP);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_fetch_req", ifu_rd_req, 1);
        check("mid_rst_fetch_addr", ifu_rd_addr, 12'o0200);

        cur_pc = 12'o0200;
        mem[12'o7777] = 12'o6000;
        for (int n = 0; n < 40; n++) begin
            run_one(cur_pc, 12'($urandom_range(0, 4095)), $urandom_range(0, 15), cur_pc);
        end
        mem[12'o7777] = 12'o6000;
        run_one(cur_pc, 12'o7777, 2, cur_pc);
        run_one(cur_pc, 12'o0000, 0, cur_pc);
        check("wrap_pc", cur_pc, 12'o0000);
        run_one(cur_pc, 12'o0123, 4, cur_pc);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
